// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ps2_pkg                                                 |
// | Purpose  : Shared constants, prefix FSM state encoding and the     |
// |            set-2 scan-code to ASCII lookup for the PS/2 decoder.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package ps2_pkg;

  // Prefix bytes and the two shift make codes
  localparam logic [7:0] c_BREAK   = 8'hF0;
  localparam logic [7:0] c_EXTEND  = 8'hE0;
  localparam logic [7:0] c_SHIFT_L = 8'h12;
  localparam logic [7:0] c_SHIFT_R = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

  typedef struct packed {
    logic       hit;
    logic [7:0] ascii;
  } key_map_t;

  // Letters map to lowercase first; shift folds them to uppercase afterwards
  // so digits and control keys stay unaffected by shift.
  function automatic key_map_t scan_to_ascii(input logic [7:0] code, input logic shift);
    key_map_t m;
    m.hit   = 1'b1;
    m.ascii = 8'h00;
    case (code)
      8'h1C: m.ascii = 8'h61; 8'h32: m.ascii = 8'h62; 8'h21: m.ascii = 8'h63;
      8'h23: m.ascii = 8'h64; 8'h24: m.ascii = 8'h65; 8'h2B: m.ascii = 8'h66;
      8'h34: m.ascii = 8'h67; 8'h33: m.ascii = 8'h68; 8'h43: m.ascii = 8'h69;
      8'h3B: m.ascii = 8'h6A; 8'h42: m.ascii = 8'h6B; 8'h4B: m.ascii = 8'h6C;
      8'h3A: m.ascii = 8'h6D; 8'h31: m.ascii = 8'h6E; 8'h44: m.ascii = 8'h6F;
      8'h4D: m.ascii = 8'h70; 8'h15: m.ascii = 8'h71; 8'h2D: m.ascii = 8'h72;
      8'h1B: m.ascii = 8'h73; 8'h2C: m.ascii = 8'h74; 8'h3C: m.ascii = 8'h75;
      8'h2A: m.ascii = 8'h76; 8'h1D: m.ascii = 8'h77; 8'h22: m.ascii = 8'h78;
      8'h35: m.ascii = 8'h79; 8'h1A: m.ascii = 8'h7A;
      8'h45: m.ascii = 8'h30; 8'h16: m.ascii = 8'h31; 8'h1E: m.ascii = 8'h32;
      8'h26: m.ascii = 8'h33; 8'h25: m.ascii = 8'h34; 8'h2E: m.ascii = 8'h35;
      8'h36: m.ascii = 8'h36; 8'h3D: m.ascii = 8'h37; 8'h3E: m.ascii = 8'h38;
      8'h46: m.ascii = 8'h39;
      8'h29: m.ascii = 8'h20;
      8'h5A: m.ascii = 8'h0D;
      8'h66: m.ascii = 8'h08;
      default: m.hit = 1'b0;
    endcase
    if (shift && (m.ascii >= 8'h61) && (m.ascii <= 8'h7A))
      m.ascii = m.ascii - 8'h20;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ps2_key_decoder_if                                      |
// | Purpose  : Scan-byte input strobe and ASCII valid/ready output     |
// |            handshake of the PS/2 key decoder.                      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface ps2_key_decoder_if;
  logic [7:0] scan_data;
  logic       scan_valid;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_ascii;

  // Byte receiver plus game consumer side
  modport master (
    output scan_data, scan_valid, out_ready,
    input  out_valid, out_ascii
  );

  // Decoder side
  modport slave (
    input  scan_data, scan_valid, out_ready,
    output out_valid, out_ascii
  );
endinterface
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : key_fifo                                                |
// | Purpose  : DEPTH x 8 FIFO for key-press ASCII codes with fill      |
// |            count and sticky overflow flag.                         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module key_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     i_push,
  input  wire logic [7:0]               i_din,
  input  wire logic                     i_pop,
  output logic [7:0]                    o_dout,
  output logic                          o_valid,
  output logic [$clog2(DEPTH):0]        o_fill,
  output logic                          o_overflow
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_FULL_CNT);
  assign w_pop_ok  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  // Storage write; contents need no reset since the head is gated by empty
  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_push && !w_push_ok)
        r_overflow <= 1'b1;
    end
  end

  assign o_dout     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign o_valid    = !w_empty;
  assign o_fill     = r_count;
  assign o_overflow = r_overflow;
endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ps2_key_decoder                                         |
// | Purpose  : PS/2 set-2 scan bytes to queued ASCII key-press events  |
// |            with break/extended prefix tracking, shift state and    |
// |            typematic repeat suppression.                           |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  ps2_key_decoder_if.slave          bus,
  output logic [7:0]                held_ascii,
  output logic                      shift_held,
  output logic [$clog2(DEPTH):0]    fill,
  output logic                      overflow
);
  prefix_state_t r_state;
  prefix_state_t w_state_next;

  logic       w_make;
  logic       w_break;
  logic       w_push;
  logic       w_shift;
  key_map_t   w_map;

  logic       r_shift_l;
  logic       r_shift_r;
  logic [7:0] r_held_code;
  logic [7:0] r_held_ascii;

  // Prefix state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  // Prefix decode: classify each strobed byte as make, break or ignored
  always_comb begin
    w_state_next = r_state;
    w_make       = 1'b0;
    w_break      = 1'b0;
    if (bus.scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.scan_data == c_BREAK)
            w_state_next = ST_BRK;
          else if (bus.scan_data == c_EXTEND)
            w_state_next = ST_EXT;
          else
            w_make = 1'b1;
        end
        ST_BRK: begin
          w_break      = 1'b1;
          w_state_next = ST_IDLE;
        end
        ST_EXT: begin
          w_state_next = (bus.scan_data == c_BREAK) ? ST_EXT_BRK : ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  assign w_shift = r_shift_l | r_shift_r;
  assign w_map   = scan_to_ascii(bus.scan_data, w_shift);
  // Repeats of the key already held down are typematic and not re-queued
  assign w_push  = w_make && w_map.hit && (bus.scan_data != r_held_code);

  // Shift flags and the most recent still-held key
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift_l    <= 1'b0;
      r_shift_r    <= 1'b0;
      r_held_code  <= 8'h00;
      r_held_ascii <= 8'h00;
    end else begin
      if (w_make && (bus.scan_data == c_SHIFT_L))  r_shift_l <= 1'b1;
      if (w_break && (bus.scan_data == c_SHIFT_L)) r_shift_l <= 1'b0;
      if (w_make && (bus.scan_data == c_SHIFT_R))  r_shift_r <= 1'b1;
      if (w_break && (bus.scan_data == c_SHIFT_R)) r_shift_r <= 1'b0;
      if (w_push) begin
        r_held_code  <= bus.scan_data;
        r_held_ascii <= w_map.ascii;
      end else if (w_break && (bus.scan_data == r_held_code)) begin
        r_held_code  <= 8'h00;
        r_held_ascii <= 8'h00;
      end
    end
  end

  key_fifo #(
    .DEPTH (DEPTH)
  ) u_key_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_din      (w_map.ascii),
    .i_pop      (bus.out_ready),
    .o_dout     (bus.out_ascii),
    .o_valid    (bus.out_valid),
    .o_fill     (fill),
    .o_overflow (overflow)
  );

  assign held_ascii = r_held_ascii;
  assign shift_held = w_shift;
endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_ps2_key_decoder                                      |
// | Purpose  : Directed self-checking bench for ps2_key_decoder.       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic       clk;
  logic       reset;
  logic [7:0] held_ascii;
  logic       shift_held;
  logic [3:0] fill;
  logic       overflow;

  int n_chk;
  int n_bad;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .held_ascii (held_ascii),
    .shift_held (shift_held),
    .fill       (fill),
    .overflow   (overflow)
  );

  // 100 MHz free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.scan_data  = b;
    bus.scan_valid = 1'b1;
    tick();
    bus.scan_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_chk          = 0;
    n_bad          = 0;
    reset          = 1'b0;
    bus.scan_data  = 8'h00;
    bus.scan_valid = 1'b0;
    bus.out_ready  = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_ascii", 32'(bus.out_ascii), 32'h00);
    chk("rst_held",  32'(held_ascii),    32'h00);
    chk("rst_shift", 32'(shift_held),    32'h0);
    chk("rst_fill",  32'(fill),          32'h0);
    chk("rst_ovf",   32'(overflow),      32'h0);
    chk("rst_state", 32'(dut.r_state),   32'(ST_IDLE));
    reset = 1'b1;
    tick();

    // 1C F0 1C -> one 'a', held then released
    send(8'h1C);
    chk("a_valid", 32'(bus.out_valid), 32'h1);
    chk("a_ascii", 32'(bus.out_ascii), 32'h61);
    chk("a_held",  32'(held_ascii),    32'h61);
    send(8'hF0);
    send(8'h1C);
    chk("a_held_rel", 32'(held_ascii), 32'h00);
    chk("a_fill",     32'(fill),       32'h1);
    chk("a_state",    32'(dut.r_state), 32'(ST_IDLE));
    pop_one();
    chk("a_pop_fill",  32'(fill),          32'h0);
    chk("a_pop_ascii", 32'(bus.out_ascii), 32'h00);
    chk("a_pop_valid", 32'(bus.out_valid), 32'h0);

    // Shifted A
    send(8'h12);
    chk("sh_on", 32'(shift_held), 32'h1);
    send(8'h1C);
    chk("sh_ascii", 32'(bus.out_ascii), 32'h41);
    send(8'hF0);
    send(8'h1C);
    chk("sh_still", 32'(shift_held), 32'h1);
    send(8'hF0);
    send(8'h12);
    chk("sh_off",   32'(shift_held), 32'h0);
    chk("sh_fill",  32'(fill),       32'h1);
    chk("sh_state", 32'(dut.r_state), 32'(ST_IDLE));
    pop_one();

    // Typematic repeat suppression
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    chk("rep_fill1", 32'(fill), 32'h1);
    send(8'hF0);
    send(8'h1C);
    send(8'h1C);
    chk("rep_fill2", 32'(fill),          32'h2);
    chk("rep_head1", 32'(bus.out_ascii), 32'h61);
    pop_one();
    chk("rep_head2", 32'(bus.out_ascii), 32'h61);
    pop_one();
    chk("rep_empty", 32'(fill), 32'h0);

    // Extended make/break ignored, then 'v'
    send(8'hE0);
    send(8'h75);
    chk("ext_state1", 32'(dut.r_state), 32'(ST_IDLE));
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("ext_fill0",  32'(fill), 32'h0);
    chk("ext_state2", 32'(dut.r_state), 32'(ST_IDLE));
    send(8'h2A);
    chk("ext_fill1", 32'(fill),          32'h1);
    chk("ext_ascii", 32'(bus.out_ascii), 32'h76);
    pop_one();

    // Fill to full and overflow with nine distinct letters a..i
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    send(8'h24); send(8'h2B); send(8'h34); send(8'h33);
    chk("full_fill8", 32'(fill),     32'h8);
    chk("full_ovf0",  32'(overflow), 32'h0);
    send(8'h43);
    chk("ovf_fill", 32'(fill),          32'h8);
    chk("ovf_flag", 32'(overflow),      32'h1);
    chk("ovf_head", 32'(bus.out_ascii), 32'h61);
    bus.out_ready = 1'b1;
    send(8'h3B);
    bus.out_ready = 1'b0;
    chk("pp_fill", 32'(fill),          32'h8);
    chk("pp_head", 32'(bus.out_ascii), 32'h62);
    chk("pp_ovf",  32'(overflow),      32'h1);

    // Drain to three entries, then asynchronous reset after a break prefix
    bus.out_ready = 1'b1;
    repeat (5) tick();
    bus.out_ready = 1'b0;
    chk("drain_fill", 32'(fill), 32'h3);
    send(8'hF0);
    chk("pre_state", 32'(dut.r_state), 32'(ST_BRK));
    #2;
    reset = 1'b0;
    #1;
    chk("ar_fill",  32'(fill),          32'h0);
    chk("ar_ascii", 32'(bus.out_ascii), 32'h00);
    chk("ar_valid", 32'(bus.out_valid), 32'h0);
    chk("ar_ovf",   32'(overflow),      32'h0);
    chk("ar_state", 32'(dut.r_state),   32'(ST_IDLE));
    tick();
    reset = 1'b1;
    tick();
    send(8'h1C);
    chk("post_fill",  32'(fill),          32'h1);
    chk("post_ascii", 32'(bus.out_ascii), 32'h61);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Converts the raw PS/2 scan-code byte stream from the keyboard receiver into debounced ASCII key-press events for the typing-game logic. It sits between the PS/2 byte receiver and the game/VGA top that compares typed characters against falling letters. It tracks break (F0) and extended (E0) prefixes and shift state, and suppresses typematic repeats. Each new press is queued in a small FIFO with a valid/ready handshake, so the game consumes one character per match check.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `scan_data`  in  8  scan-code byte from receiver.
- `scan_valid`  in  1  one-cycle strobe; `scan_data` valid this cycle.
- `out_ready`  in  1  consumer accepts head entry this cycle.
- `out_valid`  out  1  FIFO non-empty.
- `out_ascii`  out  8  head ASCII code; 0x00 when empty.
- `held_ascii`  out  8  ASCII of most recent still-held key; 0x00 if none.
- `shift_held`  out  1  either shift key down.
- `fill`  out  $clog2(DEPTH)+1  entries in FIFO.
- `overflow`  out  1  sticky; a press was dropped because FIFO full.

## Operation
- Prefix FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0). Advances only on `scan_valid`.
  - IDLE: F0→BRK; E0→EXT; any other byte is a make code, processed, stay IDLE.
  - BRK: byte is a break code, processed, →IDLE.
  - EXT: F0→EXT_BRK; other byte ignored (extended make), →IDLE.
  - EXT_BRK: byte ignored, →IDLE.
- Make code 0x12 or 0x59 sets that shift flag; the matching break clears it. `shift_held` = OR of both flags.
- Make code, mapped, not equal to held code: push ASCII, set held code and `held_ascii`.
- Make code equal to held code (typematic repeat): no push.
- Break of held code: clear held code and `held_ascii` to 0x00.
- Break of any other code: no effect on held state.
- Map: letters a–z (set-2 codes 0x1C…0x1A) → 0x61–0x7A; with shift → 0x41–0x5A. Digits 0x45,0x16…0x46 → 0x30–0x39, unaffected by shift. 0x29→0x20, 0x5A→0x0D, 0x66→0x08. Other codes are unmapped and produce no push and no held change.
- FIFO handshake:
  - Pop when `out_valid & out_ready`.
  - Push when full without a same-cycle pop: entry dropped, `overflow` set.
  - Push and pop when full: both take effect, `fill` unchanged.
  - Pop when empty: ignored.

## Timing
- Reset values: FSM IDLE; `out_valid`=0, `out_ascii`=0x00, `held_ascii`=0x00, `shift_held`=0, `fill`=0, `overflow`=0; FIFO pointers 0.
- Lookup is combinational. Push occurs on the edge sampling `scan_valid`, so `out_valid`/`out_ascii` reflect the press the next cycle (latency 1).
- `held_ascii` and `shift_held` update on the same edge.
- Pop takes effect on the sampling edge. The next head (or 0x00) appears the following cycle.
- Pointers wrap modulo DEPTH. `fill` counts 0…DEPTH.
- `scan_valid` back-to-back every cycle is supported; one byte per cycle.
- `reset` low mid-sequence (e.g. after F0) returns the FSM to IDLE and empties the FIFO immediately. It does not wait for a clock edge.
- `overflow` clears only on reset.

## Structure
- Shared package `ps2_pkg`: prefix constants (0xF0, 0xE0), shift codes, the enum for the four FSM states, and the scan-to-ASCII lookup function.
- Sub-module `key_fifo`, parameterised by DEPTH × 8 bits: push, pop, full/empty, fill, overflow. The top holds the FSM, shift/held tracking and lookup.

## Test plan
- Bytes 1C, F0, 1C → one entry 0x61, `out_valid` one cycle after the 1C strobe. `held_ascii` reads 0x61, then 0x00 after the break.
- Bytes 12, 1C, F0, 1C, F0, 12 → entry 0x41. `shift_held` reads 1 between the 12 make and the final 12 break.
- Bytes 1C, 1C, 1C (typematic), F0, 1C, 1C → exactly two entries, both 0x61.
- Bytes E0, 75, E0, F0, 75, then 2A → one entry 0x76 only. FSM is IDLE after each sequence.
- Nine distinct makes with `out_ready`=0 and DEPTH=8: `fill`=8, `overflow`=1, head 0x61. Then `out_ready`=1 held with a simultaneous make: `fill` stays 8 on that cycle.
- Reset low after F0 with 3 entries queued → `fill`=0, `out_ascii`=0x00 without a clock edge. Subsequent 1C is treated as a make → entry 0x61.
